lcd_cmd_seq: RTL and testbench

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

---
 rtl/lcd_cmd_pkg.sv | 25 ++
 rtl/lcd_seq_timer.sv | 26 ++
 rtl/lcd_cmd_seq.sv | 125 ++++++++++++
 tb/tb_lcd_cmd_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cmd_pkg.sv
// Shared definitions for the LCD command sequencer: opcodes, FSM states, defaults.
package lcd_cmd_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_UP    = 3'b001;
  localparam logic [2:0] CMD_DOWN  = 3'b010;
  localparam logic [2:0] CMD_LEFT  = 3'b011;
  localparam logic [2:0] CMD_RIGHT = 3'b100;
  localparam logic [2:0] CMD_AVG   = 3'b101;
  localparam logic [2:0] CMD_MIRX  = 3'b110;
  localparam logic [2:0] CMD_MIRY  = 3'b111;

  localparam int unsigned GAP_DEFAULT     = 2;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_Q    = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/lcd_seq_timer.sv
// Loadable down-counter that stops at zero; zero flags an expired interval.
module lcd_seq_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_cmd_seq.sv
// Script-driven command sequencer: fetches opcodes from a ROM and strobes them
// to an LCD controller, enforcing a minimum gap and a done timeout.
module lcd_cmd_seq
  import lcd_cmd_pkg::*;
#(
  parameter int unsigned GAP     = GAP_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] CROM_Q,
  output logic       CROM_EN,
  output logic [4:0] CROM_A,
  input  logic       busy,
  input  logic       done,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       err,
  output logic [5:0] cmd_cnt
);

  localparam int unsigned GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  seq_state_t state;
  logic [2:0] op_r;
  logic       last_r;
  logic       issue;
  logic       tmo_load;
  logic       gap_zero;
  logic       tmo_zero;

  assign issue    = (state == ISSUE) && !busy && gap_zero;
  assign tmo_load = issue && (op_r == CMD_WRITE);

  lcd_seq_timer #(.WIDTH(GW)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .load     (issue),
    .load_val (GW'(GAP)),
    .zero     (gap_zero)
  );

  // Loaded with TIMEOUT-1 so zero is seen in the TIMEOUT-th WAIT_DONE cycle.
  lcd_seq_timer #(.WIDTH(TW)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .load_val (TW'(TIMEOUT - 1)),
    .zero     (tmo_zero)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      CROM_A    <= '0;
      CROM_EN   <= 1'b1;
      cmd       <= CMD_WRITE;
      cmd_valid <= 1'b0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
      err       <= 1'b0;
      cmd_cnt   <= '0;
      op_r      <= CMD_WRITE;
      last_r    <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            state    <= FETCH;
            CROM_A   <= '0;
            CROM_EN  <= 1'b0;
            seq_busy <= 1'b1;
            seq_done <= 1'b0;
            err      <= 1'b0;
            cmd_cnt  <= '0;
          end
        end
        FETCH: begin
          CROM_EN <= 1'b1;
          state   <= WAIT_Q;
        end
        WAIT_Q: begin
          op_r   <= CROM_Q[2:0];
          last_r <= CROM_Q[3];
          state  <= ISSUE;
        end
        ISSUE: begin
          if (issue) begin
            cmd_valid <= 1'b1;
            cmd       <= op_r;
            if (cmd_cnt != 6'd63)
              cmd_cnt <= cmd_cnt + 6'd1;
            if (op_r == CMD_WRITE) begin
              state <= WAIT_DONE;
            end else if (!last_r && (CROM_A != 5'd31)) begin
              CROM_A  <= CROM_A + 5'd1;
              CROM_EN <= 1'b0;
              state   <= FETCH;
            end else begin
              // Stay in ISSUE; the appended write reuses the normal issue path.
              op_r <= CMD_WRITE;
            end
          end
        end
        WAIT_DONE: begin
          if (done || tmo_zero) begin
            state    <= FINISH;
            seq_busy <= 1'b0;
            seq_done <= 1'b1;
            if (!done)
              err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq: directed scenarios plus randomized
// scripts checked against a script-level model of the expected command stream.
module tb_lcd_cmd_seq;
  import lcd_cmd_pkg::*;

  localparam int unsigned GAP     = 2;
  localparam int unsigned TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic [3:0] CROM_Q = '0;
  logic       CROM_EN;
  logic [4:0] CROM_A;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       seq_busy;
  logic       seq_done;
  logic       err;
  logic [5:0] cmd_cnt;

  logic [3:0] rom [32];
  logic [2:0] obs_q [$];
  logic [2:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_strobe = -1;
  int         exp_addr = 0;
  logic       busy_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_cmd_seq #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .CROM_Q    (CROM_Q),
    .CROM_EN   (CROM_EN),
    .CROM_A    (CROM_A),
    .busy      (busy),
    .done      (done),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .err       (err),
    .cmd_cnt   (cmd_cnt)
  );

  // Synchronous script ROM: data appears the cycle after an enabled address.
  always @(posedge clk) if (!CROM_EN) CROM_Q <= rom[CROM_A];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stream monitor: fetch addresses, strobe capture, busy and spacing rules.
  always @(negedge clk) begin
    if (!reset) begin
      if (!CROM_EN) begin
        check("fetch_addr", 32'(CROM_A), exp_addr);
        exp_addr++;
      end
      if (cmd_valid) begin
        obs_q.push_back(cmd);
        check("busy_before_strobe", 32'(busy_prev), 0);
        if (last_strobe >= 0)
          check("strobe_spacing_ok", 32'((cyc - last_strobe) >= int'(GAP + 1)), 1);
        last_strobe = cyc;
      end
    end
    busy_prev = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the script until a write, a last flag or the final entry.
  task automatic build_expected();
    logic [3:0] e;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      e = rom[i];
      exp_q.push_back(e[2:0]);
      if (e[2:0] == CMD_WRITE) break;
      if (e[3] || i == 31) begin
        exp_q.push_back(CMD_WRITE);
        break;
      end
    end
  endtask

  task automatic fill_random(input int unsigned pct_last, input int unsigned pct_write);
    logic [2:0] op;
    for (int i = 0; i < 32; i++) begin
      op = 3'($urandom_range(7, 1));
      if ($urandom_range(99, 0) < pct_write) op = CMD_WRITE;
      rom[i] = {($urandom_range(99, 0) < pct_last), op};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_crom_a"},    32'(CROM_A), 0);
    check({tag, "_crom_en"},   32'(CROM_EN), 1);
    check({tag, "_cmd"},       32'(cmd), 0);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
    check({tag, "_seq_busy"},  32'(seq_busy), 0);
    check({tag, "_seq_done"},  32'(seq_done), 0);
    check({tag, "_err"},       32'(err), 0);
    check({tag, "_cmd_cnt"},   32'(cmd_cnt), 0);
  endtask

  task automatic pulse_start(input logic with_done);
    obs_q.delete();
    exp_addr    = 0;
    last_strobe = -1;
    start = 1'b1;
    done  = with_done;
    tick();
    start = 1'b0;
    done  = 1'b0;
    check("start_seq_busy", 32'(seq_busy), 1);
    check("start_seq_done", 32'(seq_done), 0);
    check("start_err",      32'(err), 0);
    check("start_cmd_cnt",  32'(cmd_cnt), 0);
  endtask

  task automatic wait_strobes(input int n, input int unsigned busy_pct, input int unsigned start_pct);
    int k = 0;
    while (obs_q.size() < n && k < 3000) begin
      busy  = ($urandom_range(99, 0) < busy_pct);
      start = seq_busy && ($urandom_range(99, 0) < start_pct);
      tick();
      k++;
    end
    start = 1'b0;
    check("strobes_in_time", 32'(obs_q.size() >= n), 1);
  endtask

  task automatic finish_script(input int done_delay, input int unsigned busy_pct);
    int k = 0;
    int ns;
    if (done_delay >= 0) begin
      repeat (done_delay) begin
        busy = ($urandom_range(99, 0) < busy_pct);
        tick();
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      while (!seq_done && k < int'(TIMEOUT) + 50) begin
        tick();
        k++;
      end
    end else begin
      ns = last_strobe;
      while (cyc < ns + int'(TIMEOUT) - 1) tick();
      check("tmo_not_early", 32'(seq_done), 0);
      tick();
    end
    busy = 1'b0;
    check("end_seq_done", 32'(seq_done), 1);
    check("end_seq_busy", 32'(seq_busy), 0);
    check("end_err",      32'(err), (done_delay < 0) ? 1 : 0);
    check("end_cmd_cnt",  32'(cmd_cnt), (exp_q.size() > 63) ? 63 : exp_q.size());
    check("op_count",     32'(obs_q.size()), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("op_value", 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_script(input int unsigned busy_pct, input int unsigned start_pct,
                            input int done_delay, input logic with_done);
    build_expected();
    pulse_start(with_done);
    wait_strobes(exp_q.size(), busy_pct, start_pct);
    finish_script(done_delay, busy_pct);
  endtask

  initial begin
    // Reset state, with start held high to show it is ignored during reset.
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    check("idle_no_start", 32'(seq_busy), 0);

    // Plain four-command script ending in a scripted write.
    fill_random(50, 20);
    rom[0] = 4'b0001; rom[1] = 4'b0100; rom[2] = 4'b0101; rom[3] = 4'b1000;
    run_script(0, 0, 4, 1'b0);

    // Last flag on a non-write: appended write follows.
    fill_random(50, 20);
    rom[0] = 4'b0011; rom[1] = 4'b1110;
    run_script(0, 0, 2, 1'b0);

    // busy held for 10 cycles while the first command waits in ISSUE.
    fill_random(50, 20);
    rom[0] = 4'b0001; rom[1] = 4'b1000;
    build_expected();
    busy = 1'b1;
    pulse_start(1'b0);
    repeat (9) tick();
    check("busy_stall_no_strobe", 32'(obs_q.size()), 0);
    busy = 1'b0;
    tick();
    busy = 1'b1;
    tick();
    check("busy_release_one_strobe", 32'(obs_q.size()), 1);
    repeat (4) tick();
    check("busy_hold_second", 32'(obs_q.size()), 1);
    busy = 1'b0;
    wait_strobes(exp_q.size(), 0, 0);
    finish_script(3, 0);

    // done never arrives: timeout after exactly TIMEOUT WAIT_DONE cycles.
    fill_random(50, 20);
    rom[0] = 4'b1000;
    run_script(0, 0, -1, 1'b0);

    // Reset during the gap after the second command, then a clean restart.
    fill_random(50, 20);
    rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0011; rom[3] = 4'b1000;
    build_expected();
    pulse_start(1'b0);
    wait_strobes(2, 0, 0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_reset_outputs("abort");
    repeat (4) tick();
    check("abort_no_more_strobes", 32'(obs_q.size()), 2);
    check("abort_idle", 32'(seq_busy), 0);
    run_script(0, 0, 3, 1'b0);

    // Full 32-entry script with no write and no last flag.
    fill_random(0, 0);
    run_script(0, 0, 2, 1'b0);

    // Randomized scripts, busy, done delay, stray starts, start+done in FINISH.
    for (int unsigned it = 0; it < 25; it++) begin
      fill_random($urandom_range(30, 3), $urandom_range(20, 0));
      run_script($urandom_range(40, 0), 5, int'($urandom_range(40, 0)), 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
